// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and types for the bouncing-sprite block:
//                default active-area size, 8-entry sprite palette and the
//                motion-update FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default active area (800x600)
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  // Sprite palette, entry 0 in the low bits:
  // fff, f00, 0f0, 00f, ff0, 0ff, f0f, 777
  localparam logic [7:0][11:0] PALETTE = {
    12'h777, 12'hf0f, 12'h0ff, 12'hff0,
    12'h00f, 12'h0f0, 12'hf00, 12'hfff
  };

  // Motion-update sequencer: idle until a frame tick, latch candidates,
  // then commit them.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CALC  = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  // Palette lookup helper
  function automatic logic [11:0] palette_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_mover.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_mover
//  Description : Single-axis motion step for the sprite. Given the current
//                position, direction (1 = increasing) and step size, produces
//                the next position/direction and flags a bounce when the
//                sprite would leave [0, LIMIT]. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_mover #(
  parameter int LIMIT = 768
) (
  input  logic [11:0] pos_i,
  input  logic        dir_i,
  input  logic [11:0] step_i,
  output logic [11:0] pos_o,
  output logic        dir_o,
  output logic        bounce_o
);

  localparam logic [11:0] C_LIMIT = 12'(LIMIT);

  logic [11:0] w_sum;
  logic [11:0] w_diff;

  // 12-bit arithmetic leaves headroom so pos+step never wraps
  assign w_sum  = pos_i + step_i;
  assign w_diff = pos_i - step_i;

  // Clamp to the edge and reverse when the step would overshoot; landing
  // exactly on the edge is a normal move, the reversal comes next update.
  always_comb begin
    pos_o    = pos_i;
    dir_o    = dir_i;
    bounce_o = 1'b0;
    if (dir_i) begin
      if (w_sum > C_LIMIT) begin
        pos_o    = C_LIMIT;
        dir_o    = 1'b0;
        bounce_o = 1'b1;
      end else begin
        pos_o = w_sum;
      end
    end else begin
      if (pos_i < step_i) begin
        pos_o    = 12'd0;
        dir_o    = 1'b1;
        bounce_o = 1'b1;
      end else begin
        pos_o = w_diff;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_bounce_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : vga_bounce_sprite
//  Description : One square sprite that bounces around the active area.
//                Motion is updated once every FRAME_DIV frames, in the three
//                cycles following the rising edge of VBlank, so the picture
//                never tears. Each bounce advances the sprite colour through
//                an 8-entry palette. Pixel hit/colour are combinational from
//                the scan position for zero added latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int SIZE      = 32,
  parameter int X_INIT    = 100,
  parameter int Y_INIT    = 100,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic        CLK_100MHz,
  input  logic        RESET_N,
  input  logic [10:0] CurrentX,
  input  logic [10:0] CurrentY,
  input  logic        VBlank,
  input  logic        HBlank,
  input  logic        PAUSE,
  input  logic [1:0]  SPEED,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        yes
);

  localparam logic [11:0] C_X_INIT   = 12'(X_INIT);
  localparam logic [11:0] C_Y_INIT   = 12'(Y_INIT);
  localparam logic [11:0] C_STEP_X   = 12'(STEP_X);
  localparam logic [11:0] C_STEP_Y   = 12'(STEP_Y);
  localparam logic [11:0] C_SIZE     = 12'(SIZE);
  localparam logic [15:0] C_DIV_LAST = 16'(FRAME_DIV - 1);

  // Architectural state
  state_e      state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        vb_dly_q;
  logic [11:0] pos_x_q, pos_y_q;
  logic        dir_x_q, dir_y_q;
  logic [2:0]  pal_idx_q;

  // Candidates latched in CALC, committed in APPLY
  logic [11:0] cand_x_q, cand_y_q;
  logic        cand_dx_q, cand_dy_q;
  logic        bx_q, by_q;

  // Combinational step/mover results
  logic [11:0] w_mult;
  logic [11:0] w_sx, w_sy;
  logic [11:0] w_cand_x, w_cand_y;
  logic        w_cand_dx, w_cand_dy;
  logic        w_bx, w_by;
  logic        w_tick;

  assign w_tick = VBlank & ~vb_dly_q;
  assign w_mult = {10'd0, SPEED} + 12'd1;
  assign w_sx   = C_STEP_X * w_mult;
  assign w_sy   = C_STEP_Y * w_mult;

  vga_axis_mover #(
    .LIMIT (H_ACTIVE - SIZE)
  ) u_mover_x (
    .pos_i    (pos_x_q),
    .dir_i    (dir_x_q),
    .step_i   (w_sx),
    .pos_o    (w_cand_x),
    .dir_o    (w_cand_dx),
    .bounce_o (w_bx)
  );

  vga_axis_mover #(
    .LIMIT (V_ACTIVE - SIZE)
  ) u_mover_y (
    .pos_i    (pos_y_q),
    .dir_i    (dir_y_q),
    .step_i   (w_sy),
    .pos_o    (w_cand_y),
    .dir_o    (w_cand_dy),
    .bounce_o (w_by)
  );

  // FSM state and frame divider registers
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_WAIT;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state: the divider keeps counting while paused, only motion stops
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (w_tick) begin
          if (frame_cnt_q == C_DIV_LAST) begin
            frame_cnt_d = 16'd0;
            if (!PAUSE) begin
              state_d = ST_CALC;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      ST_CALC:  state_d = ST_APPLY;
      ST_APPLY: state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Position/direction/palette datapath and VBlank edge detector
  always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      vb_dly_q  <= 1'b1;
      pos_x_q   <= C_X_INIT;
      pos_y_q   <= C_Y_INIT;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      pal_idx_q <= 3'd0;
      cand_x_q  <= C_X_INIT;
      cand_y_q  <= C_Y_INIT;
      cand_dx_q <= 1'b1;
      cand_dy_q <= 1'b1;
      bx_q      <= 1'b0;
      by_q      <= 1'b0;
    end else begin
      vb_dly_q <= VBlank;
      if (state_q == ST_CALC) begin
        cand_x_q  <= w_cand_x;
        cand_y_q  <= w_cand_y;
        cand_dx_q <= w_cand_dx;
        cand_dy_q <= w_cand_dy;
        bx_q      <= w_bx;
        by_q      <= w_by;
      end
      if (state_q == ST_APPLY) begin
        pos_x_q <= cand_x_q;
        pos_y_q <= cand_y_q;
        dir_x_q <= cand_dx_q;
        dir_y_q <= cand_dy_q;
        // A corner hit counts as a single bounce
        if (bx_q | by_q) begin
          pal_idx_q <= pal_idx_q + 3'd1;
        end
      end
    end
  end

  logic [11:0] w_cx, w_cy;
  logic        w_in_x, w_in_y;
  logic [11:0] w_rgb;

  assign w_cx   = {1'b0, CurrentX};
  assign w_cy   = {1'b0, CurrentY};
  assign w_in_x = (w_cx >= pos_x_q) && (w_cx < (pos_x_q + C_SIZE));
  assign w_in_y = (w_cy >= pos_y_q) && (w_cy < (pos_y_q + C_SIZE));

  // Pixel hit test and colour, blanked outside the active area
  always_comb begin
    yes   = ~VBlank & ~HBlank & w_in_x & w_in_y;
    w_rgb = 12'h000;
    if (yes) begin
      w_rgb = palette_lookup(pal_idx_q);
    end
    red   = w_rgb[11:8];
    green = w_rgb[7:4];
    blue  = w_rgb[3:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_bounce_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_bounce_sprite
//  Description : Directed testbench for vga_bounce_sprite. Three instances
//                share the stimulus: default parameters, a corner-bounce
//                configuration and a FRAME_DIV=3 configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_bounce_sprite;
  import vga_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [10:0] cx, cy;
  logic        vb, hb, pause;
  logic [1:0]  speed;

  logic [3:0] r_def, g_def, b_def;  logic y_def;
  logic [3:0] r_cor, g_cor, b_cor;  logic y_cor;
  logic [3:0] r_div, g_div, b_div;  logic y_div;

  int n_checks = 0;
  int n_errors = 0;

  vga_bounce_sprite u_def (
    .CLK_100MHz(clk), .RESET_N(rst_n), .CurrentX(cx), .CurrentY(cy),
    .VBlank(vb), .HBlank(hb), .PAUSE(pause), .SPEED(speed),
    .red(r_def), .green(g_def), .blue(b_def), .yes(y_def)
  );

  vga_bounce_sprite #(.X_INIT(766), .Y_INIT(566), .STEP_Y(2)) u_cor (
    .CLK_100MHz(clk), .RESET_N(rst_n), .CurrentX(cx), .CurrentY(cy),
    .VBlank(vb), .HBlank(hb), .PAUSE(pause), .SPEED(speed),
    .red(r_cor), .green(g_cor), .blue(b_cor), .yes(y_cor)
  );

  vga_bounce_sprite #(.FRAME_DIV(3)) u_div (
    .CLK_100MHz(clk), .RESET_N(rst_n), .CurrentX(cx), .CurrentY(cy),
    .VBlank(vb), .HBlank(hb), .PAUSE(pause), .SPEED(speed),
    .red(r_div), .green(g_div), .blue(b_div), .yes(y_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame: drop VBlank, raise it, leave time for the 3-cycle update
  task automatic frame();
    @(negedge clk);
    vb = 1'b0;
    repeat (3) @(negedge clk);
    vb = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vb    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Place the scan position in the active area and let outputs settle
  task automatic probe(input int x, input int y, input logic h);
    vb = 1'b0;
    hb = h;
    cx = 11'(x);
    cy = 11'(y);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cx = '0; cy = '0; vb = 1'b0; hb = 1'b0;
    pause = 1'b0; speed = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_x",   32'(u_def.pos_x_q), 32'd100);
    check_eq("rst_y",   32'(u_def.pos_y_q), 32'd100);
    check_eq("rst_dir", 32'({u_def.dir_x_q, u_def.dir_y_q}), 32'h3);
    check_eq("rst_pal", 32'(u_def.pal_idx_q), 32'd0);
    check_eq("rst_st",  32'(u_def.state_q), 32'(ST_WAIT));
    probe(100, 100, 1'b0);
    check_eq("rst_hit", 32'(y_def), 32'd1);
    check_eq("rst_rgb", 32'({r_def, g_def, b_def}), 32'hfff);

    // First update and its latency
    @(negedge clk);
    vb = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("lat2_x", 32'(u_def.pos_x_q), 32'd100);
    @(negedge clk);
    check_eq("lat3_x", 32'(u_def.pos_x_q), 32'd102);
    check_eq("lat3_y", 32'(u_def.pos_y_q), 32'd101);
    check_eq("lat3_pal", 32'(u_def.pal_idx_q), 32'd0);
    probe(102, 101, 1'b0);
    check_eq("hit_tl", 32'(y_def), 32'd1);
    probe(101, 101, 1'b0);
    check_eq("hit_left", 32'(y_def), 32'd0);
    probe(134, 101, 1'b0);
    check_eq("hit_right", 32'(y_def), 32'd0);
    probe(133, 132, 1'b0);
    check_eq("hit_br", 32'(y_def), 32'd1);
    probe(133, 133, 1'b0);
    check_eq("hit_below", 32'(y_def), 32'd0);
    vb = 1'b1; #1;
    check_eq("hit_vblank", 32'(y_def), 32'd0);

    // Edge landing and corner bounce
    do_reset();
    frame();
    check_eq("cor1_x",  32'(u_cor.pos_x_q), 32'd768);
    check_eq("cor1_y",  32'(u_cor.pos_y_q), 32'd568);
    check_eq("cor1_dir", 32'({u_cor.dir_x_q, u_cor.dir_y_q}), 32'h3);
    check_eq("cor1_pal", 32'(u_cor.pal_idx_q), 32'd0);
    frame();
    check_eq("cor2_x",  32'(u_cor.pos_x_q), 32'd768);
    check_eq("cor2_y",  32'(u_cor.pos_y_q), 32'd568);
    check_eq("cor2_dir", 32'({u_cor.dir_x_q, u_cor.dir_y_q}), 32'h0);
    check_eq("cor2_pal", 32'(u_cor.pal_idx_q), 32'd1);
    probe(768, 568, 1'b0);
    check_eq("cor2_hit", 32'(y_cor), 32'd1);
    check_eq("cor2_rgb", 32'({r_cor, g_cor, b_cor}), 32'hf00);
    frame();
    check_eq("cor3_x",  32'(u_cor.pos_x_q), 32'd766);
    check_eq("cor3_y",  32'(u_cor.pos_y_q), 32'd566);
    check_eq("cor3_pal", 32'(u_cor.pal_idx_q), 32'd1);

    // Frame divider without pause
    do_reset();
    frame(); frame();
    check_eq("div2_x", 32'(u_div.pos_x_q), 32'd100);
    frame();
    check_eq("div3_x", 32'(u_div.pos_x_q), 32'd102);

    // Frame divider with pause over ticks 3..6
    do_reset();
    frame(); frame();
    pause = 1'b1;
    frame();
    check_eq("pz3_x", 32'(u_div.pos_x_q), 32'd100);
    frame(); frame(); frame();
    check_eq("pz6_x", 32'(u_div.pos_x_q), 32'd100);
    pause = 1'b0;
    frame(); frame();
    check_eq("pz8_x", 32'(u_div.pos_x_q), 32'd100);
    frame();
    check_eq("pz9_x", 32'(u_div.pos_x_q), 32'd102);
    check_eq("pz9_y", 32'(u_div.pos_y_q), 32'd101);

    // Speed multiplier and HBlank masking
    do_reset();
    speed = 2'd3;
    frame();
    check_eq("spd_x", 32'(u_def.pos_x_q), 32'd108);
    check_eq("spd_y", 32'(u_def.pos_y_q), 32'd104);
    probe(110, 106, 1'b1);
    check_eq("hb_hit", 32'(y_def), 32'd0);
    check_eq("hb_rgb", 32'({r_def, g_def, b_def}), 32'h000);
    probe(110, 106, 1'b0);
    check_eq("spd_hit", 32'(y_def), 32'd1);
    hb = 1'b0;
    speed = 2'd0;

    // Reset during CALC, released inside VBlank
    do_reset();
    vb = 1'b1;
    @(negedge clk);
    check_eq("mid_calc", 32'(u_def.state_q), 32'(ST_CALC));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_st", 32'(u_def.state_q), 32'(ST_WAIT));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("mid_hold_x", 32'(u_def.pos_x_q), 32'd100);
    check_eq("mid_hold_y", 32'(u_def.pos_y_q), 32'd100);
    frame();
    check_eq("mid_next_x", 32'(u_def.pos_x_q), 32'd102);
    check_eq("mid_next_y", 32'(u_def.pos_y_q), 32'd101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
